// File: rtl/btn_filter_pkg.sv
// rtl/btn_filter_pkg.sv - shared types and parameter checks for the multi-channel button filter
//
// Contents:
//   hold_state_e  per-channel hold FSM encoding (IDLE, PRESS, HELD)
//   MIN_TICKS     smallest legal long-press / repeat interval
//   ticks_legal   true when a tick count fits its hold counter width

package btn_filter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRESS = 2'd1,
      HELD  = 2'd2
   } hold_state_e;

   localparam int MIN_TICKS = 1;

   // The threshold compare uses (ticks - 1), so the count itself must fit in width bits.
   function automatic bit ticks_legal(input int ticks, input int width);
      return (ticks >= MIN_TICKS) && (ticks < (1 << width));
   endfunction

endpackage

// File: rtl/btn_filter_ch.sv
// rtl/btn_filter_ch.sv - single-channel synchroniser, debouncer, hold FSM and event pulses
//
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   ce           filter tick, one clk wide
//   rpt_en       auto-repeat enable for this channel
//   btn_in       raw asynchronous input
//   btn_out      filtered level, 1 = pressed
//   rise, fall   1-clk pulses in the cycle btn_out changes
//   long_p       1-clk pulse when the press reaches LONG_TICKS
//   rpt_p        1-clk pulse every RPT_TICKS while held past long-press

module btn_filter_ch
   import btn_filter_pkg::*;
#(
   parameter int   CNTR_WIDTH = 4,
   parameter int   HOLD_WIDTH = 10,
   parameter int   LONG_TICKS = 1000,
   parameter int   RPT_TICKS  = 200,
   parameter logic ACTIVE_LOW = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic ce,
   input  logic rpt_en,
   input  logic btn_in,
   output logic btn_out,
   output logic rise,
   output logic fall,
   output logic long_p,
   output logic rpt_p
);

   localparam logic [HOLD_WIDTH-1:0] LONG_LAST = HOLD_WIDTH'(LONG_TICKS - 1);
   localparam logic [HOLD_WIDTH-1:0] RPT_LAST  = HOLD_WIDTH'(RPT_TICKS - 1);

   logic                  sync_d;
   logic                  sync_s1;
   logic [CNTR_WIDTH-1:0] stab_cnt;
   logic                  accept;
   logic                  release_now;

   hold_state_e           state;
   hold_state_e           state_next;
   logic [HOLD_WIDTH-1:0] hold_cnt;
   logic [HOLD_WIDTH-1:0] hold_cnt_next;
   logic                  long_next;
   logic                  rpt_next;

   // The synchronised level has disagreed for a full counter period and this CE completes it.
   assign accept      = ce && (sync_s1 != btn_out) && (stab_cnt == '1);
   // Release is known one edge early so it can suppress a coincident long/repeat threshold.
   assign release_now = accept && !sync_s1;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_d   <= 1'b0;
         sync_s1  <= 1'b0;
         stab_cnt <= '0;
         btn_out  <= 1'b0;
         rise     <= 1'b0;
         fall     <= 1'b0;
         long_p   <= 1'b0;
         rpt_p    <= 1'b0;
         state    <= IDLE;
         hold_cnt <= '0;
      end else begin
         sync_d  <= btn_in ^ ACTIVE_LOW;
         sync_s1 <= sync_d;
         rise    <= accept && sync_s1;
         fall    <= release_now;
         long_p  <= long_next;
         rpt_p   <= rpt_next;
         if (sync_s1 == btn_out) begin
            stab_cnt <= '0;
         end else if (ce) begin
            // All-ones wraps to zero on the accepting tick.
            stab_cnt <= stab_cnt + CNTR_WIDTH'(1);
         end
         if (accept) begin
            btn_out <= sync_s1;
         end
         state    <= state_next;
         hold_cnt <= hold_cnt_next;
      end
   end

   // IDLE with btn_out already high behaves like PRESS, so press duration counts every CE
   // after the accepting edge and LONG can never land on the RISE cycle.
   always_comb begin
      state_next    = state;
      hold_cnt_next = hold_cnt;
      long_next     = 1'b0;
      rpt_next      = 1'b0;
      if (!btn_out || release_now) begin
         state_next    = IDLE;
         hold_cnt_next = '0;
      end else begin
         case (state)
            IDLE, PRESS: begin
               state_next = PRESS;
               if (ce) begin
                  if (hold_cnt == LONG_LAST) begin
                     long_next     = 1'b1;
                     hold_cnt_next = '0;
                     state_next    = HELD;
                  end else begin
                     hold_cnt_next = hold_cnt + HOLD_WIDTH'(1);
                  end
               end
            end
            HELD: begin
               if (!rpt_en) begin
                  // Dropping enable restarts a full interval on the next enable.
                  hold_cnt_next = '0;
               end else if (ce) begin
                  if (hold_cnt == RPT_LAST) begin
                     rpt_next      = 1'b1;
                     hold_cnt_next = '0;
                  end else begin
                     hold_cnt_next = hold_cnt + HOLD_WIDTH'(1);
                  end
               end
            end
            default: begin
               state_next    = IDLE;
               hold_cnt_next = '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/btn_filter_multi.sv
// rtl/btn_filter_multi.sv - N_CH-channel button filter with polarity, edge, long-press and repeat pulses
//
// Ports:
//   CLK, RST      system clock, synchronous active-high reset
//   CE            filter tick, one CLK wide
//   RPT_EN        per-channel auto-repeat enable
//   BTN_IN        raw asynchronous inputs
//   BTN_OUT       filtered, polarity-corrected levels
//   BTN_RISE_CEO  accepted-press pulses
//   BTN_FALL_CEO  accepted-release pulses
//   BTN_LONG_CEO  long-press pulses
//   BTN_RPT_CEO   auto-repeat pulses
//   ANY_PRESSED   registered OR of BTN_OUT

module btn_filter_multi
   import btn_filter_pkg::*;
#(
   parameter int              N_CH       = 4,
   parameter int              CNTR_WIDTH = 4,
   parameter int              HOLD_WIDTH = 10,
   parameter int              LONG_TICKS = 1000,
   parameter int              RPT_TICKS  = 200,
   parameter logic [N_CH-1:0] ACTIVE_LOW = '0
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            CE,
   input  logic [N_CH-1:0] RPT_EN,
   input  logic [N_CH-1:0] BTN_IN,
   output logic [N_CH-1:0] BTN_OUT,
   output logic [N_CH-1:0] BTN_RISE_CEO,
   output logic [N_CH-1:0] BTN_FALL_CEO,
   output logic [N_CH-1:0] BTN_LONG_CEO,
   output logic [N_CH-1:0] BTN_RPT_CEO,
   output logic            ANY_PRESSED
);

   localparam bit PARAMS_OK = ticks_legal(LONG_TICKS, HOLD_WIDTH) &&
                              ticks_legal(RPT_TICKS, HOLD_WIDTH);

   // An illegal tick configuration builds no channels, leaving an obviously dead block.
   if (PARAMS_OK) begin : g_legal
      for (genvar i = 0; i < N_CH; i++) begin : g_ch
         btn_filter_ch #(
            .CNTR_WIDTH (CNTR_WIDTH),
            .HOLD_WIDTH (HOLD_WIDTH),
            .LONG_TICKS (LONG_TICKS),
            .RPT_TICKS  (RPT_TICKS),
            .ACTIVE_LOW (ACTIVE_LOW[i])
         ) u_ch (
            .clk     (CLK),
            .rst     (RST),
            .ce      (CE),
            .rpt_en  (RPT_EN[i]),
            .btn_in  (BTN_IN[i]),
            .btn_out (BTN_OUT[i]),
            .rise    (BTN_RISE_CEO[i]),
            .fall    (BTN_FALL_CEO[i]),
            .long_p  (BTN_LONG_CEO[i]),
            .rpt_p   (BTN_RPT_CEO[i])
         );
      end
   end else begin : g_illegal
      assign BTN_OUT      = '0;
      assign BTN_RISE_CEO = '0;
      assign BTN_FALL_CEO = '0;
      assign BTN_LONG_CEO = '0;
      assign BTN_RPT_CEO  = '0;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         ANY_PRESSED <= 1'b0;
      end else begin
         ANY_PRESSED <= |BTN_OUT;
      end
   end

endmodule

// File: tb/tb_btn_filter_multi.sv
// tb/tb_btn_filter_multi.sv - self-checking bench for btn_filter_multi against a tick-counting model

module tb_btn_filter_multi;

   localparam int         N_CH = 4;
   localparam int         CW   = 2;
   localparam int         HW   = 4;
   localparam int         LONG = 5;
   localparam int         RPT  = 3;
   localparam logic [3:0] AL   = 4'b1000;

   logic       CLK = 1'b0;
   logic       RST;
   logic       CE;
   logic [3:0] RPT_EN;
   logic [3:0] BTN_IN;
   logic [3:0] BTN_OUT;
   logic [3:0] BTN_RISE_CEO;
   logic [3:0] BTN_FALL_CEO;
   logic [3:0] BTN_LONG_CEO;
   logic [3:0] BTN_RPT_CEO;
   logic       ANY_PRESSED;

   always #5 CLK = ~CLK;

   btn_filter_multi #(
      .N_CH       (N_CH),
      .CNTR_WIDTH (CW),
      .HOLD_WIDTH (HW),
      .LONG_TICKS (LONG),
      .RPT_TICKS  (RPT),
      .ACTIVE_LOW (AL)
   ) dut (
      .CLK          (CLK),
      .RST          (RST),
      .CE           (CE),
      .RPT_EN       (RPT_EN),
      .BTN_IN       (BTN_IN),
      .BTN_OUT      (BTN_OUT),
      .BTN_RISE_CEO (BTN_RISE_CEO),
      .BTN_FALL_CEO (BTN_FALL_CEO),
      .BTN_LONG_CEO (BTN_LONG_CEO),
      .BTN_RPT_CEO  (BTN_RPT_CEO),
      .ANY_PRESSED  (ANY_PRESSED)
   );

   int tests = 0;
   int fails = 0;

   // Stimulus state
   logic       rst_v = 1'b1;
   logic       ce_v  = 1'b0;
   logic [3:0] rpt_v = 4'b0000;
   logic [3:0] btn_v = 4'b0000;
   int         ce_mode = 0;
   int         cyc_n = 0;
   int         ce_ticks = 0;
   int         n_rise[4];
   int         n_fall[4];
   int         n_long[4];
   int         n_rpt[4];

   // Reference model: expected register contents after each edge
   logic [3:0] m_d, m_s1, m_lvl, m_rise, m_fall, m_long, m_rpt;
   logic       m_any;
   int         m_run[4];     // consecutive CE ticks the synchronised input disagreed
   int         m_press[4];   // CE ticks since the press was accepted
   int         m_rptrun[4];  // enabled CE ticks since the last repeat (or long) pulse

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_n);
      end
   endtask

   task automatic model_step(input logic rst, input logic ce, input logic [3:0] rpt,
                             input logic [3:0] btn);
      logic acc;
      if (rst) begin
         m_d = '0; m_s1 = '0; m_lvl = '0; m_rise = '0; m_fall = '0;
         m_long = '0; m_rpt = '0; m_any = 1'b0;
         for (int c = 0; c < N_CH; c++) begin
            m_run[c] = 0; m_press[c] = 0; m_rptrun[c] = 0;
         end
         return;
      end
      m_any = |m_lvl;
      for (int c = 0; c < N_CH; c++) begin
         m_rise[c] = 1'b0; m_fall[c] = 1'b0; m_long[c] = 1'b0; m_rpt[c] = 1'b0;
         acc = 1'b0;
         if (m_s1[c] == m_lvl[c]) begin
            m_run[c] = 0;
         end else if (ce) begin
            m_run[c]++;
            if (m_run[c] == (1 << CW)) begin
               acc = 1'b1;
               m_run[c] = 0;
            end
         end
         if (acc && !m_s1[c]) begin
            m_fall[c] = 1'b1; m_lvl[c] = 1'b0; m_press[c] = 0; m_rptrun[c] = 0;
         end else if (m_lvl[c]) begin
            if (m_press[c] >= LONG && !rpt[c]) begin
               m_rptrun[c] = 0;
            end else if (ce) begin
               m_press[c]++;
               if (m_press[c] == LONG) begin
                  m_long[c] = 1'b1;
               end else if (m_press[c] > LONG) begin
                  m_rptrun[c]++;
                  if (m_rptrun[c] == RPT) begin
                     m_rpt[c] = 1'b1;
                     m_rptrun[c] = 0;
                  end
               end
            end
         end else if (acc) begin
            m_rise[c] = 1'b1; m_lvl[c] = 1'b1; m_press[c] = 0; m_rptrun[c] = 0;
         end
      end
      m_s1 = m_d;
      m_d  = btn ^ AL;
   endtask

   task automatic sample();
      @(negedge CLK);
      check_eq("btn_out", 32'(BTN_OUT), 32'(m_lvl));
      check_eq("rise",    32'(BTN_RISE_CEO), 32'(m_rise));
      check_eq("fall",    32'(BTN_FALL_CEO), 32'(m_fall));
      check_eq("long",    32'(BTN_LONG_CEO), 32'(m_long));
      check_eq("rpt",     32'(BTN_RPT_CEO), 32'(m_rpt));
      check_eq("any",     32'(ANY_PRESSED), 32'(m_any));
      for (int c = 0; c < N_CH; c++) begin
         n_rise[c] += int'(BTN_RISE_CEO[c]);
         n_fall[c] += int'(BTN_FALL_CEO[c]);
         n_long[c] += int'(BTN_LONG_CEO[c]);
         n_rpt[c]  += int'(BTN_RPT_CEO[c]);
      end
   endtask

   task automatic drive();
      case (ce_mode)
         0:       ce_v = (cyc_n % 4 == 0);
         1:       ce_v = 1'b1;
         default: ce_v = ($urandom_range(0, 2) == 0);
      endcase
      cyc_n++;
      if (ce_v && !rst_v) ce_ticks++;
      RST = rst_v; CE = ce_v; RPT_EN = rpt_v; BTN_IN = btn_v;
      model_step(rst_v, ce_v, rpt_v, btn_v);
   endtask

   task automatic cyc();
      sample();
      drive();
   endtask

   task automatic clear_tally();
      for (int c = 0; c < N_CH; c++) begin
         n_rise[c] = 0; n_fall[c] = 0; n_long[c] = 0; n_rpt[c] = 0;
      end
   endtask

   // Returns after a sample() that saw BTN_OUT[ch] == val; the caller must drive() next.
   task automatic wait_out(input int ch, input logic val, input string tag);
      for (int i = 0; i < 300; i++) begin
         sample();
         if (BTN_OUT[ch] == val) break;
         drive();
      end
      check_eq(tag, 32'(BTN_OUT[ch]), 32'(val));
   endtask

   task automatic hold_ticks(input int n);
      for (int g = 0; g < 2000 && ce_ticks < n; g++) cyc();
   endtask

   initial begin
      clear_tally();
      RST = 1'b1; CE = 1'b0; RPT_EN = '0; BTN_IN = '0;
      model_step(1'b1, 1'b0, '0, '0);
      repeat (3) @(posedge CLK);

      // Reset state
      rst_v = 1'b0;
      sample();
      check_eq("rst_out",  32'(BTN_OUT), 0);
      check_eq("rst_rise", 32'(BTN_RISE_CEO), 0);
      check_eq("rst_long", 32'(BTN_LONG_CEO), 0);
      check_eq("rst_any",  32'(ANY_PRESSED), 0);
      drive();

      // Active-low channel 3 is pressed from reset
      wait_out(3, 1'b1, "al_accept");
      check_eq("al_rise", 32'(BTN_RISE_CEO[3]), 1);
      drive();

      // Debounce on channel 0
      btn_v[0] = 1'b1;
      wait_out(0, 1'b1, "a_accept");
      check_eq("a_rise", 32'(BTN_RISE_CEO[0]), 1);
      drive();

      // Glitch on channel 1: 3 ticks only
      clear_tally(); ce_ticks = 0;
      btn_v[1] = 1'b1;
      hold_ticks(3);
      btn_v[1] = 1'b0;
      repeat (40) cyc();
      check_eq("b_glitch_rise", 32'(n_rise[1]), 0);
      check_eq("b_glitch_out",  32'(BTN_OUT[1]), 0);

      // Long press and repeat on channel 2
      rpt_v[2] = 1'b1; btn_v[2] = 1'b1;
      wait_out(2, 1'b1, "c_accept");
      clear_tally(); ce_ticks = 0;
      drive();
      hold_ticks(20);
      sample();
      check_eq("c_long_cnt", 32'(n_long[2]), 1);
      check_eq("c_rpt_cnt",  32'(n_rpt[2]), 5);
      drive();
      btn_v[2] = 1'b0;
      wait_out(2, 1'b0, "c_release");
      check_eq("c_fall", 32'(BTN_FALL_CEO[2]), 1);
      drive();

      // Same hold with repeat disabled
      rpt_v[2] = 1'b0; btn_v[2] = 1'b1;
      wait_out(2, 1'b1, "d_accept");
      clear_tally(); ce_ticks = 0;
      drive();
      hold_ticks(20);
      sample();
      check_eq("d_long_cnt", 32'(n_long[2]), 1);
      check_eq("d_rpt_cnt",  32'(n_rpt[2]), 0);
      drive();
      btn_v[2] = 1'b0;
      wait_out(2, 1'b0, "d_release");
      drive();

      // Release accepted on the same tick as the long threshold
      rpt_v[2] = 1'b1; btn_v[2] = 1'b1;
      wait_out(2, 1'b1, "e_accept");
      clear_tally(); ce_ticks = 0;
      drive();
      hold_ticks(1);
      btn_v[2] = 1'b0;
      wait_out(2, 1'b0, "e_release");
      check_eq("e_release_tick", 32'(ce_ticks), 5);
      check_eq("e_fall", 32'(BTN_FALL_CEO[2]), 1);
      drive();
      repeat (12) cyc();
      check_eq("e_long_cnt", 32'(n_long[2]), 0);
      check_eq("e_fall_cnt", 32'(n_fall[2]), 1);

      // Reset while channel 2 is held
      btn_v[2] = 1'b1;
      wait_out(2, 1'b1, "f_accept");
      ce_ticks = 0;
      drive();
      hold_ticks(8);
      rst_v = 1'b1;
      cyc();
      rst_v = 1'b0;
      sample();
      check_eq("f_rst_out",  32'(BTN_OUT), 0);
      check_eq("f_rst_rpt",  32'(BTN_RPT_CEO), 0);
      check_eq("f_rst_long", 32'(BTN_LONG_CEO), 0);
      check_eq("f_rst_any",  32'(ANY_PRESSED), 0);
      drive();
      wait_out(2, 1'b1, "f_reaccept");
      check_eq("f_rerise", 32'(BTN_RISE_CEO[2]), 1);
      clear_tally(); ce_ticks = 0;
      drive();
      hold_ticks(LONG);
      sample();
      check_eq("f_long_cnt", 32'(n_long[2]), 1);
      drive();

      // Randomized traffic across all CE modes
      for (int blk = 0; blk < 16; blk++) begin
         ce_mode = int'($urandom_range(0, 2));
         for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 29) == 0) btn_v[$urandom_range(0, 3)] ^= 1'b1;
            if ($urandom_range(0, 79) == 0) rpt_v[$urandom_range(0, 3)] ^= 1'b1;
            rst_v = ($urandom_range(0, 599) == 0);
            cyc();
         end
      end
      rst_v = 1'b0;
      cyc();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/btn_filter_multi.md
Name: btn_filter_multi

Overview:
- Multi-channel successor to the single-button debouncer.
- Filters N_CH asynchronous button or switch inputs with a CE-gated stability counter.
- Adds per-channel polarity, rise and fall pulses, long-press detection and auto-repeat.
- Sits between board I/O pins and control logic (UART controller command keys, mode switches). All outputs are CLK-synchronous and usable directly as clock enables.

Parameters:
- N_CH, 4: number of independent button channels.
- CNTR_WIDTH, 4: stability counter width. A level must hold 2^CNTR_WIDTH CE ticks to be accepted.
- HOLD_WIDTH, 10: long-press/repeat counter width.
- LONG_TICKS, 1000: CE ticks of continuous press before BTN_LONG_CEO fires. Must satisfy 1 <= LONG_TICKS < 2^HOLD_WIDTH.
- RPT_TICKS, 200: CE ticks between auto-repeat pulses. Must satisfy 1 <= RPT_TICKS < 2^HOLD_WIDTH.
- ACTIVE_LOW, {N_CH{1'b0}}: per-channel mask. 1 = input inverted before synchronisation.

Ports:
- CLK  in  1  system clock.
- RST  in  1  reset, synchronous, active-high; one clock; all state cleared on the CLK edge where RST=1.
- CE  in  1  filter tick (1-2 kHz optimal), one CLK wide.
- RPT_EN  in  N_CH  per-channel auto-repeat enable.
- BTN_IN  in  N_CH  raw asynchronous inputs.
- BTN_OUT  out  N_CH  filtered, polarity-corrected level (1 = pressed).
- BTN_RISE_CEO  out  N_CH  1-CLK pulse on accepted press.
- BTN_FALL_CEO  out  N_CH  1-CLK pulse on accepted release.
- BTN_LONG_CEO  out  N_CH  1-CLK pulse when press reaches LONG_TICKS.
- BTN_RPT_CEO  out  N_CH  1-CLK pulse every RPT_TICKS while held past long-press with RPT_EN=1.
- ANY_PRESSED  out  1  registered OR of BTN_OUT.

Behaviour:
- Reset: every output 0, all synchroniser stages 0, all counters 0, every channel FSM in IDLE.
- Per channel, apply polarity: x = BTN_IN ^ ACTIVE_LOW. Then a 2-FF synchroniser: D <= x, S1 <= D.
- Stability counter:
  - Cleared on any CLK where S1 == BTN_OUT.
  - Otherwise incremented on CE.
  - When the counter is all-ones and CE=1: BTN_OUT <= S1 and the counter wraps to 0.
- Latency from a stable input change to BTN_OUT: 2 CLK + exactly 2^CNTR_WIDTH CE ticks.
- A glitch shorter than that clears the counter and leaves BTN_OUT unchanged.
- BTN_RISE_CEO / BTN_FALL_CEO are registered and asserted in the same cycle BTN_OUT changes: rise for 0->1, fall for 1->0. Never both in one cycle.
- Hold FSM per channel, states IDLE, PRESS, HELD. The hold counter is HOLD_WIDTH bits.
  - IDLE: hold counter 0. Go to PRESS when BTN_OUT becomes 1.
  - PRESS: counter increments on CE. On the CE where count == LONG_TICKS-1: pulse BTN_LONG_CEO next cycle, clear counter, go to HELD.
  - HELD, RPT_EN=1: counter increments on CE. On the CE where count == RPT_TICKS-1: pulse BTN_RPT_CEO, clear counter, stay in HELD.
  - HELD, RPT_EN=0: counter held at 0, no pulses.
  - Dropping RPT_EN mid-interval clears the counter, so the next enable restarts a full interval.
  - Any state: BTN_OUT becomes 0 -> IDLE, counter cleared.
- Simultaneous events:
  - Release and a long/repeat threshold on the same CE: release wins, no LONG/RPT pulse.
  - A LONG pulse is never coincident with a RISE pulse, since LONG_TICKS >= 1.
- CE held at 1 continuously is legal: ticks then count every CLK.
- RST mid-operation: everything returns to reset values next edge. No pulse is emitted on the reset edge or the edge after it.
- Channels are fully independent; no cross-channel priority.
- ANY_PRESSED is registered one cycle after BTN_OUT (|BTN_OUT delayed).

Decomposition:
- Package btn_filter_pkg holds:
  - the FSM state encoding (IDLE=2'd0, PRESS=2'd1, HELD=2'd2);
  - parameter legality check constants.
- One sub-module, btn_filter_ch: synchroniser, stability counter, hold FSM and pulses for a single channel, scalar ports.
- Top-level btn_filter_multi instantiates N_CH copies via generate, slices ACTIVE_LOW per channel, and registers ANY_PRESSED.

Test Plan:
- Debounce (CNTR_WIDTH=2, CE every 4 CLK): BTN_IN[0] 0->1 stable -> BTN_OUT[0]=1 exactly 2 CLK + 4 CE ticks later, with one-CLK BTN_RISE_CEO[0] in the same cycle. Other channels stay 0.
- Glitch: BTN_IN[1] high for 3 CE ticks then low -> BTN_OUT[1] never rises, no pulses.
- Long press and repeat (LONG_TICKS=5, RPT_TICKS=3, RPT_EN=1): hold 20 ticks after acceptance -> LONG pulse at tick 5, RPT pulses at ticks 8, 11, 14, 17, 20. Release -> one FALL pulse, FSM returns to IDLE.
- RPT_EN=0 for the same hold -> LONG pulse only, no RPT pulses. Release at exactly tick 5 (same CE as threshold) -> FALL only, no LONG.
- ACTIVE_LOW=4'b1000, BTN_IN[3] held 0 from reset -> BTN_OUT[3]=1 after 2 CLK + 2^CNTR_WIDTH ticks, with RISE pulse.
- RST asserted for 1 CLK while channel 2 is in HELD -> all outputs 0 next cycle. With input still pressed, re-acceptance produces a fresh RISE, then LONG after LONG_TICKS.
